centroid_tracker: RTL and testbench

Downstream of the skin-threshold stage in the video pipeline. Consumes the binary mask stream with its de/h_sync/v_sync, and accumulates the X/Y coordinate sums and the pixel count of object pixels over each frame. During vertical blanking it divides these sequentially to produce the object centroid. It forwards the video one cycle late, optionally overlaying a crosshair at the previous frame's centroid.

---
 rtl/centroid_pkg.sv | 22 ++
 rtl/seq_divider.sv | 71 +++++++
 rtl/centroid_tracker.sv | 170 +++++++++++++++++
 tb/tb_centroid_tracker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared constants and FSM state type for the centroid tracker.
// The crosshair overlay in centroid_tracker is enabled by defining CENTROID_MARKER_EN.
package centroid_pkg;

  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 720;
  localparam int XW_DEF    = 11;
  localparam int YW_DEF    = 10;
  localparam int SW_DEF    = 32;
  localparam int NW_DEF    = 20;

  localparam logic [23:0] MARKER_COLOR = 24'hFF0000;
  localparam int          DIV_ITER     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_X  = 2'd1,
    DIV_Y  = 2'd2,
    UPDATE = 2'd3
  } ct_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock.
// The start edge loads the operands and retires the first bit.
// The quotient is final when done pulses, DIV_ITER edges after start.
module seq_divider
  import centroid_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic [SW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(DIV_ITER) + 1;

  logic [NW-1:0] rem_q;
  logic [NW-1:0] div_q;
  logic [CW-1:0] iter_q;
  logic          busy_q;

  logic [NW-1:0] src_rem;
  logic [NW-1:0] src_div;
  logic [SW-1:0] src_quot;
  logic [NW:0]   shifted;
  logic          take;
  logic [NW-1:0] nxt_rem;

  // Operands come straight from the ports on the start edge, from the registers afterwards.
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_div  = start ? divisor : div_q;
    src_quot = start ? dividend : quotient;
    shifted  = {src_rem, src_quot[SW-1]};
    take     = (shifted >= {1'b0, src_div});
    nxt_rem  = take ? NW'(shifted - {1'b0, src_div}) : shifted[NW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      div_q    <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= nxt_rem;
        div_q    <= divisor;
        quotient <= {src_quot[SW-2:0], take};
        iter_q   <= CW'(1);
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        rem_q    <= nxt_rem;
        quotient <= {src_quot[SW-2:0], take};
        iter_q   <= iter_q + CW'(1);
        if (iter_q == CW'(DIV_ITER - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/centroid_tracker.sv
// Accumulates object-pixel coordinates per frame, divides during vblank, forwards video 1 cycle late.
// Define CENTROID_MARKER_EN to overlay a crosshair at the previous frame's centroid.
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int SW    = SW_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          de_in,
  input  logic          h_sync_in,
  input  logic          v_sync_in,
  input  logic [23:0]   pixel_in,
  output logic          de_out,
  output logic          h_sync_out,
  output logic          v_sync_out,
  output logic [23:0]   pixel_out,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          centroid_valid,
  output ct_state_e     dbg_state
);

  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  ct_state_e     state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [SW-1:0] sum_x;
  logic [SW-1:0] sum_y;
  logic [NW-1:0] cnt;
  logic [SW-1:0] op_sy;
  logic [NW-1:0] op_cnt;
  logic [XW-1:0] quot_x;

  logic          fs;
  logic          de_fall;
  logic          obj;
  logic          mark_hit;
  logic          div_start;
  logic [SW-1:0] div_dividend;
  logic [NW-1:0] div_divisor;
  logic [SW-1:0] div_quot;
  logic          div_done;
  logic          unused_quot_hi;

  assign fs        = v_sync_in & ~v_sync_out;
  assign de_fall   = de_out & ~de_in;
  assign obj       = de_in && (pixel_in[23:16] == 8'h00);
  assign dbg_state = state_q;

  // X starts from the live accumulators on FS; Y starts from the snapshot when X finishes.
  assign div_start    = ((state_q == IDLE) && fs) || ((state_q == DIV_X) && div_done);
  assign div_dividend = (state_q == DIV_X) ? op_sy  : sum_x;
  assign div_divisor  = (state_q == DIV_X) ? op_cnt : cnt;

  assign unused_quot_hi = ^div_quot[SW-1:XW];

`ifdef CENTROID_MARKER_EN
  assign mark_hit = de_in && centroid_valid && ((x_q == cx) || (y_q == cy));
`else
  assign mark_hit = 1'b0;
`endif

  seq_divider #(
    .SW(SW),
    .NW(NW)
  ) u_div (
    .clk     (CLK),
    .rst     (RST),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .quotient(div_quot),
    .done    (div_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      pixel_out  <= '0;
    end else begin
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
      pixel_out  <= mark_hit ? MARKER_COLOR : pixel_in;
    end
  end

  // Counters saturate at the frame edge so an overlong line cannot alias back onto column 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q   <= '0;
      y_q   <= '0;
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else if (fs) begin
      x_q   <= '0;
      y_q   <= '0;
      sum_x <= '0;
      sum_y <= '0;
      cnt   <= '0;
    end else begin
      if (de_in) begin
        if (x_q != X_MAX) x_q <= x_q + XW'(1);
      end else if (de_fall) begin
        x_q <= '0;
        if (y_q != Y_MAX) y_q <= y_q + YW'(1);
      end
      if (obj) begin
        sum_x <= sum_x + SW'(x_q);
        sum_y <= sum_y + SW'(y_q);
        cnt   <= cnt + NW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      op_sy          <= '0;
      op_cnt         <= '0;
      quot_x         <= '0;
      cx             <= '0;
      cy             <= '0;
      centroid_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fs) begin
            op_sy   <= sum_y;
            op_cnt  <= cnt;
            state_q <= DIV_X;
          end
        end
        DIV_X: begin
          if (div_done) begin
            quot_x  <= div_quot[XW-1:0];
            state_q <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) state_q <= UPDATE;
        end
        UPDATE: begin
          // An empty frame leaves the last good centroid in place and only drops valid.
          if (op_cnt != '0) begin
            cx             <= quot_x;
            cy             <= div_quot[YW-1:0];
            centroid_valid <= 1'b1;
          end else begin
            centroid_valid <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker on a 64x16 frame with a cycle-level reference model.
module tb_centroid_tracker;
  import centroid_pkg::*;

  localparam int W  = 64;
  localparam int H  = 16;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int HB = 8;
  localparam int VB = 100;
  localparam int RW = XW + YW + 1;
  localparam logic [23:0] RED = 24'hFF0000;
`ifdef CENTROID_MARKER_EN
  localparam bit MARK_ON = 1'b1;
`else
  localparam bit MARK_ON = 1'b0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic          de_in = 1'b0;
  logic          h_sync_in = 1'b0;
  logic          v_sync_in = 1'b0;
  logic [23:0]   pixel_in = '0;
  logic          de_out;
  logic          h_sync_out;
  logic          v_sync_out;
  logic [23:0]   pixel_out;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          centroid_valid;
  ct_state_e     dbg_state;

  centroid_tracker #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .de_in         (de_in),
    .h_sync_in     (h_sync_in),
    .v_sync_in     (v_sync_in),
    .pixel_in      (pixel_in),
    .de_out        (de_out),
    .h_sync_out    (h_sync_out),
    .v_sync_out    (v_sync_out),
    .pixel_out     (pixel_out),
    .cx            (cx),
    .cy            (cy),
    .centroid_valid(centroid_valid),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad = 0;
  int cur_x = 0;
  int cur_y = 0;
  int mark_seen = 0;
  bit chk_en = 1'b0;

  // scoreboard: one {valid, cx, cy} entry per frame, consumed at that frame's FS
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] pk(input bit v, input int x, input int y);
    return {v, XW'(x), YW'(y)};
  endfunction

  // reference model: 1-cycle video delay, centroid applied 65 edges after FS
  logic          m_de, m_hs, m_vs, m_valid;
  logic [23:0]   m_pix;
  logic [XW-1:0] m_cx;
  logic [YW-1:0] m_cy;
  logic [RW-1:0] m_pend;
  int            since_fs;

  always @(posedge CLK) begin
    if (RST) begin
      m_de <= 0; m_hs <= 0; m_vs <= 0; m_pix <= '0;
      m_cx <= '0; m_cy <= '0; m_valid <= 0; m_pend <= '0;
      since_fs <= 0;
      exp_q.delete();
    end else begin
      m_de  <= de_in;
      m_hs  <= h_sync_in;
      m_vs  <= v_sync_in;
      m_pix <= (MARK_ON && de_in && m_valid && (cur_x == int'(m_cx) || cur_y == int'(m_cy)))
               ? RED : pixel_in;
      if (v_sync_in && !m_vs) begin
        since_fs <= 1;
        m_pend   <= (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      end else if (since_fs == 65) begin
        since_fs <= 0;
        if (m_pend[RW-1]) begin
          m_cx    <= m_pend[RW-2:YW];
          m_cy    <= m_pend[YW-1:0];
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (since_fs != 0) begin
        since_fs <= since_fs + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("de_out", 32'(de_out), 32'(m_de));
      chk("h_sync_out", 32'(h_sync_out), 32'(m_hs));
      chk("v_sync_out", 32'(v_sync_out), 32'(m_vs));
      chk("pixel_out", 32'(pixel_out), 32'(m_pix));
      chk("cx", 32'(cx), 32'(m_cx));
      chk("cy", 32'(cy), 32'(m_cy));
      chk("centroid_valid", 32'(centroid_valid), 32'(m_valid));
      if (de_out && pixel_out == RED) mark_seen++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic [RW-1:0] r);
    chk({tag, "_valid"}, 32'(centroid_valid), 32'(r[RW-1]));
    chk({tag, "_cx"}, 32'(cx), 32'(r[RW-2:YW]));
    chk({tag, "_cy"}, 32'(cy), 32'(r[YW-1:0]));
  endtask

  // Object pixels fill the inclusive rectangle x0..x1, y0..y1 (empty when x0 > x1).
  task automatic run_frame(input int x0, input int x1, input int y0, input int y1,
                           input int rst_at, input logic [RW-1:0] old_r,
                           input logic [RW-1:0] new_r);
    int sx = 0;
    int sy = 0;
    int n = 0;
    bit in_rect;
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) begin
        sx += xx; sy += yy; n++;
      end
    exp_q.push_back((n != 0) ? pk(1'b1, sx / n, sy / n) : '0);

    for (int yy = 0; yy < H; yy++) begin
      for (int c = 0; c < W + HB; c++) begin
        if (c < W) begin
          in_rect   = (c >= x0 && c <= x1 && yy >= y0 && yy <= y1);
          de_in     = 1'b1;
          h_sync_in = 1'b0;
          cur_x     = c;
          cur_y     = yy;
          pixel_in  = in_rect ? {8'h00, 16'($urandom)}
                              : {8'($urandom_range(1, 254)), 16'($urandom)};
        end else begin
          de_in     = 1'b0;
          h_sync_in = (c >= W + 2 && c < W + 6);
          pixel_in  = 24'($urandom);
        end
        tick();
      end
    end

    // FS edge E0 is sampled after iteration 4, so iteration j ends just after edge E(j-4)
    for (int j = 0; j < VB; j++) begin
      de_in     = 1'b0;
      h_sync_in = 1'b0;
      v_sync_in = (j >= 4 && j < 8);
      pixel_in  = 24'($urandom);
      RST       = (rst_at >= 0) && (j == rst_at + 4 || j == rst_at + 5);
      tick();
      if (rst_at >= 0 && j == rst_at + 4) begin
        chk("rst_de_out", 32'(de_out), 0);
        chk("rst_pixel_out", 32'(pixel_out), 0);
        chk("rst_v_sync_out", 32'(v_sync_out), 0);
        chk_result("rst", '0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
      end
      if (rst_at < 0 && j == 68) chk_result("e64", old_r);
      if (rst_at < 0 && j == 69) chk_result("e65", new_r);
    end
    RST = 1'b0;
  endtask

  initial begin
    // reset with random inputs
    RST = 1'b1;
    de_in = 1'($urandom); h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
    pixel_in = 24'($urandom);
    tick();
    chk_en = 1'b1;
    de_in = 1'($urandom); h_sync_in = 1'($urandom); v_sync_in = 1'($urandom);
    pixel_in = 24'($urandom);
    tick();
    chk("reset_de_out", 32'(de_out), 0);
    chk("reset_pixel_out", 32'(pixel_out), 0);
    chk("reset_h_sync_out", 32'(h_sync_out), 0);
    chk_result("reset", '0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0;
    repeat (3) tick();

    // single pixel at (10,5), exact latency pinned at E64/E65
    run_frame(10, 10, 5, 5, -1, pk(0, 0, 0), pk(1, 10, 5));

    // rectangle 20..29 x 4..7 while the crosshair sits at (10,5): 16 + 64 - 1 marked pixels
    mark_seen = 0;
    run_frame(20, 29, 4, 7, -1, pk(1, 10, 5), pk(1, 24, 5));
    chk("marker_count", 32'(mark_seen), MARK_ON ? 32'd79 : 32'd0);

    run_frame(10, 10, 5, 5, -1, pk(1, 24, 5), pk(1, 10, 5));

    // all-background frame: valid drops, coordinates hold
    run_frame(1, 0, 0, 0, -1, pk(1, 10, 5), pk(0, 10, 5));

    // reset during DIV_Y, then a clean repeat of the single-pixel frame
    run_frame(10, 10, 5, 5, 40, '0, '0);
    run_frame(10, 10, 5, 5, -1, pk(0, 0, 0), pk(1, 10, 5));

    repeat (2) tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
